// File: rtl/rombus_if.sv
// CPC expansion-bus strobes, configuration port and ROM-store fetch handshake for the ROM sequencer.
// The slave modport is the sequencer side; the master modport is the bus/board side that drives it.
interface rombus_if;
   logic       MREQ_B;
   logic       IOREQ_B;
   logic       RD_B;
   logic       WR_B;
   logic       ROMEN_B;
   logic       A15;
   logic       A14;
   logic       A13;
   logic [7:0] D;
   logic       cfg_we;
   logic [3:0] cfg_bank;
   logic       cfg_valid;
   logic       cfg_lower;
   logic       fetch_req;
   logic       fetch_lower;
   logic [7:0] fetch_bank;
   logic       fetch_ack;
   logic [7:0] fetch_data;
   logic [7:0] dout;
   logic       bufoe_b;
   logic       romdis;
   logic       wait_b;
   logic       timeout_err;

   modport slave (
      input  MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B, A15, A14, A13, D,
      input  cfg_we, cfg_bank, cfg_valid, cfg_lower, fetch_ack, fetch_data,
      output fetch_req, fetch_lower, fetch_bank, dout, bufoe_b, romdis, wait_b, timeout_err
   );

   modport master (
      output MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B, A15, A14, A13, D,
      output cfg_we, cfg_bank, cfg_valid, cfg_lower, fetch_ack, fetch_data,
      input  fetch_req, fetch_lower, fetch_bank, dout, bufoe_b, romdis, wait_b, timeout_err
   );
endinterface

// File: rtl/rombus_sequencer.sv
// Serves CPC ROM reads from an external ROM store: hit -> FETCH (wait_b low, up to WAIT_MAX cycles) -> DRIVE.
// Bus strobes are decoded from state, so async reset releases the 74245, ROMDIS and READY immediately.
module rombus_sequencer #(
   parameter int WAIT_MAX = 6,
   parameter int NBANKS   = 16
) (
   input  logic     CLK,
   input  logic     RESET_B,
   rombus_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, FETCH, DRIVE, ABORT} state_t;

   localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic [15:0]   valid_map;
   logic [7:0]    bank_q;
   logic [7:0]    dout_q;
   logic          lower_q;
   logic          terr_q;
   logic          io_wr_q;

   logic io_wr, rom_rd, upper_hit, lower_hit, hit, bus_gone, timeout;
   logic fetch_req, romdis, bufoe_b, wait_b;

   assign io_wr     = !bus.IOREQ_B && !bus.WR_B && !bus.A13;
   assign rom_rd    = !bus.MREQ_B && !bus.RD_B && !bus.ROMEN_B;
   // bank_q and valid_map are the registered values, so a same-cycle update cannot affect this hit
   assign upper_hit = bus.A15 && bus.A14 && (int'(bank_q) < NBANKS) && (bank_q < 8'd16)
                      && valid_map[bank_q[3:0]];
   assign lower_hit = !bus.A15 && !bus.A14 && bus.cfg_lower;
   assign hit       = rom_rd && (upper_hit || lower_hit);
   assign bus_gone  = bus.ROMEN_B || bus.RD_B;
   assign timeout   = (wait_cnt == CW'(WAIT_MAX - 1));

   always_comb begin
      state_nxt = state;
      fetch_req = 1'b0;
      romdis    = 1'b0;
      bufoe_b   = 1'b1;
      wait_b    = 1'b1;
      case (state)
         IDLE: begin
            if (hit) state_nxt = FETCH;
         end
         FETCH: begin
            fetch_req = 1'b1;
            romdis    = 1'b1;
            wait_b    = 1'b0;
            // a CPU that has left the cycle wins over a late acknowledge
            if (bus_gone)           state_nxt = IDLE;
            else if (bus.fetch_ack) state_nxt = DRIVE;
            else if (timeout)       state_nxt = ABORT;
         end
         DRIVE: begin
            romdis  = 1'b1;
            bufoe_b = 1'b0;
            if (bus_gone) state_nxt = IDLE;
         end
         ABORT: begin
            if (bus.ROMEN_B) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         wait_cnt  <= '0;
         valid_map <= '0;
         bank_q    <= '0;
         dout_q    <= '0;
         lower_q   <= 1'b0;
         terr_q    <= 1'b0;
         io_wr_q   <= 1'b0;
      end else begin
         wait_cnt <= (state == FETCH && state_nxt == FETCH) ? wait_cnt + CW'(1) : '0;
         io_wr_q  <= io_wr;
         // latch only on the first cycle of a held bank-port write
         if (io_wr && !io_wr_q)                     bank_q <= bus.D;
         if (bus.cfg_we)                            valid_map[bus.cfg_bank] <= bus.cfg_valid;
         if (state == IDLE && hit)                  lower_q <= !bus.A15;
         if (state == FETCH && state_nxt == DRIVE)  dout_q <= bus.fetch_data;
         if (state == FETCH && state_nxt == ABORT)  terr_q <= 1'b1;
      end
   end

   assign bus.fetch_req   = fetch_req;
   assign bus.romdis      = romdis;
   assign bus.bufoe_b     = bufoe_b;
   assign bus.wait_b      = wait_b;
   assign bus.fetch_lower = lower_q;
   assign bus.fetch_bank  = bank_q;
   assign bus.dout        = dout_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_rombus_sequencer.sv
// Self-checking bench for rombus_sequencer: each scenario task drives the CPC bus and ROM store,
// pushing expected bytes to a scoreboard queue that is popped when the DUT drives the 74245.
`timescale 1ns/1ps
module tb_rombus_sequencer;
   logic CLK = 1'b0;
   logic RESET_B = 1'b0;
   rombus_if bus();

   rombus_sequencer #(.WAIT_MAX(6), .NBANKS(16)) dut (
      .CLK     (CLK),
      .RESET_B (RESET_B),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] sb[$];
   logic [7:0] last_dout = 8'h00;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic cpc_idle();
      bus.MREQ_B = 1; bus.IOREQ_B = 1; bus.RD_B = 1; bus.WR_B = 1; bus.ROMEN_B = 1;
      bus.A15 = 0; bus.A14 = 0; bus.A13 = 0; bus.D = 8'h00;
      bus.cfg_we = 0; bus.cfg_bank = 4'h0; bus.cfg_valid = 0; bus.cfg_lower = 0;
      bus.fetch_ack = 0; bus.fetch_data = 8'h00;
   endtask

   task automatic cfg_write(input logic [3:0] bank, input logic v);
      @(negedge CLK); bus.cfg_we = 1; bus.cfg_bank = bank; bus.cfg_valid = v;
      @(negedge CLK); bus.cfg_we = 0;
   endtask

   task automatic bank_write(input logic [7:0] d);
      @(negedge CLK); bus.IOREQ_B = 0; bus.WR_B = 0; bus.A13 = 0; bus.D = d;
      @(negedge CLK); bus.IOREQ_B = 1; bus.WR_B = 1;
   endtask

   task automatic start_read(input logic upper);
      @(negedge CLK);
      bus.MREQ_B = 0; bus.RD_B = 0; bus.ROMEN_B = 0; bus.A15 = upper; bus.A14 = upper;
   endtask

   task automatic end_read();
      bus.MREQ_B = 1; bus.RD_B = 1; bus.ROMEN_B = 1;
   endtask

   // full read: ack after dly+1 sampled cycles of fetch_req, then DRIVE held 2 cycles and released
   task automatic do_read(input logic upper, input int dly, input logic [7:0] data, input logic exp_lower);
      int wl = 0, reqc = 0;
      bit done = 0;
      logic [7:0] exp;
      start_read(upper);
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge CLK);
         bus.fetch_ack = 0;
         n_chk++;
         if (!bus.bufoe_b && (!bus.wait_b || !bus.romdis)) begin
            n_fail++; $display("FAIL bus_excl: bufoe_b=%b wait_b=%b romdis=%b", bus.bufoe_b, bus.wait_b, bus.romdis);
         end
         if (!bus.wait_b) wl++;
         if (bus.fetch_req) begin
            if (reqc == 0) begin
               n_chk++;
               if (bus.fetch_lower !== exp_lower) begin
                  n_fail++; $display("FAIL fetch_lower: got %b want %b", bus.fetch_lower, exp_lower);
               end
            end
            reqc++;
            if (reqc == dly + 1) begin
               bus.fetch_ack = 1; bus.fetch_data = data; sb.push_back(data);
            end
         end
         if (!bus.bufoe_b) done = 1;
      end
      n_chk++;
      if (!done) begin n_fail++; $display("FAIL drive_wait: got no DRIVE within 30 cycles, required DRIVE"); end
      n_chk++;
      if (wl != dly + 1) begin n_fail++; $display("FAIL wait_len: got %0d want %0d", wl, dly + 1); end
      if (sb.size() > 0) begin
         exp = sb.pop_front();
         n_chk++;
         if (bus.dout !== exp) begin n_fail++; $display("FAIL dout: got %h want %h", bus.dout, exp); end
         last_dout = exp;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         n_chk++;
         if ({bus.bufoe_b, bus.romdis, bus.wait_b, bus.dout} !== {1'b0, 1'b1, 1'b1, last_dout}) begin
            n_fail++; $display("FAIL drive_hold: got oe=%b rd=%b wt=%b d=%h want 0 1 1 %h",
                               bus.bufoe_b, bus.romdis, bus.wait_b, bus.dout, last_dout);
         end
      end
      end_read();
      @(negedge CLK);
      n_chk++;
      if ({bus.bufoe_b, bus.romdis, bus.wait_b, bus.fetch_req} !== 4'b1010) begin
         n_fail++; $display("FAIL drive_release: got oe=%b rd=%b wt=%b rq=%b want 1 0 1 0",
                            bus.bufoe_b, bus.romdis, bus.wait_b, bus.fetch_req);
      end
   endtask

   task automatic no_response(input logic upper, input string name);
      start_read(upper);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         n_chk++;
         if ({bus.fetch_req, bus.romdis, bus.bufoe_b, bus.wait_b} !== 4'b0011) begin
            n_fail++; $display("FAIL %s: got rq=%b rd=%b oe=%b wt=%b want 0 0 1 1", name,
                               bus.fetch_req, bus.romdis, bus.bufoe_b, bus.wait_b);
         end
      end
      end_read();
   endtask

   task automatic test_reset();
      cpc_idle();
      RESET_B = 0;
      #1;
      n_chk++;
      if ({bus.fetch_req, bus.romdis, bus.bufoe_b, bus.wait_b, bus.fetch_lower, bus.timeout_err} !== 6'b001100) begin
         n_fail++; $display("FAIL reset_ctl: got %b want 001100",
            {bus.fetch_req, bus.romdis, bus.bufoe_b, bus.wait_b, bus.fetch_lower, bus.timeout_err});
      end
      n_chk++;
      if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
      n_chk++;
      if (bus.fetch_bank !== 8'h00) begin n_fail++; $display("FAIL reset_bank: got %h want 00", bus.fetch_bank); end
      repeat (2) @(negedge CLK);
      RESET_B = 1;
   endtask

   task automatic test_bank_port();
      cfg_write(4'd5, 1'b1);
      @(negedge CLK); bus.IOREQ_B = 0; bus.WR_B = 0; bus.A13 = 0; bus.D = 8'h05;
      @(negedge CLK); bus.D = 8'h77;
      @(negedge CLK); bus.D = 8'h66;
      @(negedge CLK); bus.IOREQ_B = 1; bus.WR_B = 1;
      n_chk++;
      if (bus.fetch_bank !== 8'h05) begin n_fail++; $display("FAIL bank_once: got %h want 05", bus.fetch_bank); end
      // configuration write coincident with a bank-port write
      @(negedge CLK);
      bus.cfg_we = 1; bus.cfg_bank = 4'd9; bus.cfg_valid = 1;
      bus.IOREQ_B = 0; bus.WR_B = 0; bus.D = 8'h09;
      @(negedge CLK);
      bus.cfg_we = 0; bus.IOREQ_B = 1; bus.WR_B = 1;
      n_chk++;
      if (bus.fetch_bank !== 8'h09) begin n_fail++; $display("FAIL bank_coinc: got %h want 09", bus.fetch_bank); end
      do_read(1'b1, 1, 8'hC3, 1'b0);
      bank_write(8'h05);
   endtask

   task automatic test_valid_read();
      do_read(1'b1, 2, 8'hA5, 1'b0);
   endtask

   task automatic test_invalid_bank();
      bank_write(8'h07);
      n_chk++;
      if (bus.fetch_bank !== 8'h07) begin n_fail++; $display("FAIL bank_7: got %h want 07", bus.fetch_bank); end
      no_response(1'b1, "invalid_bank");
      bank_write(8'h15);
      no_response(1'b1, "bank_over_nbanks");
      bank_write(8'h05);
   endtask

   task automatic test_timeout();
      int wl = 0;
      start_read(1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!bus.wait_b) wl++;
         else if (wl > 0) break;
      end
      n_chk++;
      if (wl != 6) begin n_fail++; $display("FAIL timeout_len: got %0d want 6", wl); end
      n_chk++;
      if ({bus.romdis, bus.fetch_req, bus.bufoe_b, bus.timeout_err} !== 4'b0011) begin
         n_fail++; $display("FAIL timeout_out: got rd=%b rq=%b oe=%b err=%b want 0 0 1 1",
                            bus.romdis, bus.fetch_req, bus.bufoe_b, bus.timeout_err);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         n_chk++;
         if ({bus.fetch_req, bus.romdis, bus.wait_b} !== 3'b001) begin
            n_fail++; $display("FAIL abort_hold: got rq=%b rd=%b wt=%b want 0 0 1", bus.fetch_req, bus.romdis, bus.wait_b);
         end
      end
      end_read();
      @(negedge CLK);
   endtask

   task automatic test_early_term();
      start_read(1'b1);
      @(negedge CLK);
      n_chk++;
      if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL early_req: got %b want 1", bus.fetch_req); end
      bus.RD_B = 1;
      @(negedge CLK);
      n_chk++;
      if ({bus.fetch_req, bus.romdis, bus.wait_b} !== 3'b001) begin
         n_fail++; $display("FAIL early_idle: got rq=%b rd=%b wt=%b want 0 0 1", bus.fetch_req, bus.romdis, bus.wait_b);
      end
      bus.fetch_ack = 1; bus.fetch_data = 8'h3C;
      @(negedge CLK);
      bus.fetch_ack = 0;
      n_chk++;
      if ({bus.bufoe_b, bus.dout} !== {1'b1, last_dout}) begin
         n_fail++; $display("FAIL early_ack_ignored: got oe=%b d=%h want 1 %h", bus.bufoe_b, bus.dout, last_dout);
      end
      end_read();
   endtask

   task automatic test_lower();
      bus.cfg_lower = 1;
      do_read(1'b0, 1, 8'h5A, 1'b1);
      bus.cfg_lower = 0;
      no_response(1'b0, "lower_disabled");
   endtask

   task automatic test_back_to_back();
      do_read(1'b1, 0, 8'h11, 1'b0);
      do_read(1'b1, 3, 8'h22, 1'b0);
      n_chk++;
      if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL terr_sticky: got %b want 1", bus.timeout_err); end
   endtask

   task automatic test_async_reset();
      start_read(1'b1);
      @(negedge CLK);
      bus.fetch_ack = 1; bus.fetch_data = 8'h99;
      @(negedge CLK);
      bus.fetch_ack = 0;
      n_chk++;
      if (bus.bufoe_b !== 1'b0) begin n_fail++; $display("FAIL pre_reset_drive: got oe=%b want 0", bus.bufoe_b); end
      #2 RESET_B = 0;
      #1;
      n_chk++;
      if ({bus.bufoe_b, bus.romdis, bus.wait_b, bus.fetch_req, bus.timeout_err, bus.dout} !== {5'b10100, 8'h00}) begin
         n_fail++; $display("FAIL async_reset: got oe=%b rd=%b wt=%b rq=%b err=%b d=%h want 1 0 1 0 0 00",
                            bus.bufoe_b, bus.romdis, bus.wait_b, bus.fetch_req, bus.timeout_err, bus.dout);
      end
      @(negedge CLK);
      n_chk++;
      if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req: got %b want 0", bus.fetch_req); end
      end_read();
      RESET_B = 1;
      bank_write(8'h05);
      no_response(1'b1, "valid_map_cleared");
   endtask

   initial begin
      test_reset();
      test_bank_port();
      test_valid_read();
      test_invalid_bank();
      test_timeout();
      test_early_term();
      test_lower();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
